// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the MAX10 ADC command sequencer.
package adc_seq_pkg;

    localparam int CH_W   = 5;
    localparam int DATA_W = 12;
    localparam int MAX_CH = 16;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        PUBLISH,
        SKIP,
        DONE
    } state_t;

    // Registered Avalon-ST command beat
    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] channel;
        logic            sop;
        logic            eop;
    } cmd_t;

    // Extract the channel number of one slot from the packed slot map
    function automatic logic [CH_W-1:0] slot_ch(input logic [MAX_CH*CH_W-1:0] ch_list,
                                                input logic [3:0]             slot);
        return ch_list[slot*CH_W +: CH_W];
    endfunction

endpackage

// File: rtl/adc_seq_avg.sv
// Per-slot sample accumulator with truncating power-of-two divide.
// avg_next is the average including the sample currently presented, so the
// final result can be registered on the same edge that accepts the last sample.
module adc_seq_avg
    import adc_seq_pkg::*;
#(
    parameter int AVG_LOG2 = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg_next
);

    localparam int ACC_W = DATA_W + AVG_LOG2;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // Running sum plus the presented sample, and its shifted average
    always_comb begin
        sum      = acc + ACC_W'(sample);
        avg_next = DATA_W'(sum >> AVG_LOG2);
    end

    // Accumulator register; clear has priority over add
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/adc_cmd_sequencer.sv
// Avalon-ST initiator for the MAX10 modular ADC: scans a fixed channel list,
// averages 2**AVG_LOG2 samples per slot and publishes one result per slot.
module adc_cmd_sequencer
    import adc_seq_pkg::*;
#(
    parameter int                     NUM_CH      = 4,
    parameter logic [NUM_CH*CH_W-1:0] CH_LIST     = {5'd4, 5'd3, 5'd2, 5'd1},
    parameter int                     AVG_LOG2    = 2,
    parameter int                     TIMEOUT_CYC = 1023
)(
    input  logic              clock_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic              clear_err,
    output logic              command_valid,
    output logic [CH_W-1:0]   command_channel,
    output logic              command_startofpacket,
    output logic              command_endofpacket,
    input  logic              command_ready,
    input  logic              response_valid,
    input  logic [CH_W-1:0]   response_channel,
    input  logic [DATA_W-1:0] response_data,
    input  logic              response_startofpacket,
    input  logic              response_endofpacket,
    output logic              result_valid,
    output logic [3:0]        result_slot,
    output logic [CH_W-1:0]   result_channel,
    output logic [DATA_W-1:0] result_data,
    output logic              scan_done,
    output logic              err_timeout,
    output logic              err_mismatch
);

    localparam logic [MAX_CH*CH_W-1:0] CH_LIST_EXT = (MAX_CH*CH_W)'(CH_LIST);
    localparam int                     SAMPLES     = 1 << AVG_LOG2;
    localparam int                     TMR_W       = $clog2(TIMEOUT_CYC + 1);

    state_t            state;
    cmd_t              cmd;
    cmd_t              nxt_cmd;
    logic [3:0]        slot;
    logic [3:0]        nxt_slot;
    logic [4:0]        sample;
    logic [4:0]        nxt_sample;
    logic [TMR_W-1:0]  timer;
    logic              last_sample;
    logic              last_slot;
    logic              rsp_match;
    logic              acc_clr;
    logic              acc_add;
    logic [DATA_W-1:0] avg_next;
    logic              unused_ok;

    assign command_valid         = cmd.valid;
    assign command_channel       = cmd.channel;
    assign command_startofpacket = cmd.sop;
    assign command_endofpacket   = cmd.eop;

    // Packet framing on the response stream carries no information we need
    assign unused_ok = &{1'b0, response_startofpacket, response_endofpacket};

    // Status decodes and the next command beat the FSM would issue from this state
    always_comb begin
        last_sample = (sample == 5'(SAMPLES - 1));
        last_slot   = (slot == 4'(NUM_CH - 1));
        rsp_match   = (response_channel == cmd.channel);
        acc_clr     = (state == IDLE) || (state == PUBLISH) || (state == SKIP) || (state == DONE);
        acc_add     = (state == WAIT) && response_valid && rsp_match;
        nxt_slot    = '0;
        nxt_sample  = '0;
        case (state)
            WAIT: begin
                nxt_slot   = slot;
                nxt_sample = sample + 5'd1;
            end
            PUBLISH, SKIP: begin
                nxt_slot = slot + 4'd1;
            end
            default: ;
        endcase
        nxt_cmd.valid   = 1'b1;
        nxt_cmd.channel = slot_ch(CH_LIST_EXT, nxt_slot);
        nxt_cmd.sop     = (nxt_slot == 4'd0) && (nxt_sample == 5'd0);
        nxt_cmd.eop     = (nxt_slot == 4'(NUM_CH - 1)) && (nxt_sample == 5'(SAMPLES - 1));
    end

    adc_seq_avg #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk      (clock_clk),
        .rst      (reset_reset),
        .clr      (acc_clr),
        .add      (acc_add),
        .sample   (response_data),
        .avg_next (avg_next)
    );

    // Sequencer FSM with registered command, result and status outputs.
    // Error sets are written after clear_err so a coincident new error wins.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state          <= IDLE;
            cmd            <= '0;
            slot           <= '0;
            sample         <= '0;
            timer          <= '0;
            result_valid   <= 1'b0;
            result_slot    <= '0;
            result_channel <= '0;
            result_data    <= '0;
            scan_done      <= 1'b0;
            err_timeout    <= 1'b0;
            err_mismatch   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (clear_err) begin
                err_timeout  <= 1'b0;
                err_mismatch <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state  <= SEND;
                        slot   <= nxt_slot;
                        sample <= nxt_sample;
                        cmd    <= nxt_cmd;
                    end
                end
                SEND: begin
                    if (command_ready) begin
                        cmd.valid <= 1'b0;
                        timer     <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (response_valid) begin
                        if (!rsp_match) begin
                            err_mismatch <= 1'b1;
                            state        <= enable ? SKIP : IDLE;
                        end else if (!enable) begin
                            state <= IDLE;
                        end else if (last_sample) begin
                            state          <= PUBLISH;
                            result_valid   <= 1'b1;
                            result_slot    <= slot;
                            result_channel <= cmd.channel;
                            result_data    <= avg_next;
                        end else begin
                            state  <= SEND;
                            slot   <= nxt_slot;
                            sample <= nxt_sample;
                            cmd    <= nxt_cmd;
                        end
                    end else if (timer == TMR_W'(TIMEOUT_CYC)) begin
                        err_timeout <= 1'b1;
                        state       <= enable ? SKIP : IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PUBLISH, SKIP: begin
                    if (last_slot) begin
                        state     <= DONE;
                        scan_done <= 1'b1;
                    end else if (enable) begin
                        state  <= SEND;
                        slot   <= nxt_slot;
                        sample <= nxt_sample;
                        cmd    <= nxt_cmd;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (enable) begin
                        state  <= SEND;
                        slot   <= nxt_slot;
                        sample <= nxt_sample;
                        cmd    <= nxt_cmd;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_cmd_sequencer.sv
// Scoreboard bench for adc_cmd_sequencer: a behavioural ADC responder answers
// commands, expected results are queued by the stimulus and checked by a monitor.
module tb_adc_cmd_sequencer;

    logic        clock_clk;
    logic        reset_reset;
    logic        enable;
    logic        clear_err;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;
    logic        result_valid;
    logic [3:0]  result_slot;
    logic [4:0]  result_channel;
    logic [11:0] result_data;
    logic        scan_done;
    logic        err_timeout;
    logic        err_mismatch;

    adc_cmd_sequencer #(
        .NUM_CH      (4),
        .CH_LIST     ({5'd4, 5'd3, 5'd2, 5'd1}),
        .AVG_LOG2    (2),
        .TIMEOUT_CYC (1023)
    ) dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .enable                 (enable),
        .clear_err              (clear_err),
        .command_valid          (command_valid),
        .command_channel        (command_channel),
        .command_startofpacket  (command_startofpacket),
        .command_endofpacket    (command_endofpacket),
        .command_ready          (command_ready),
        .response_valid         (response_valid),
        .response_channel       (response_channel),
        .response_data          (response_data),
        .response_startofpacket (response_startofpacket),
        .response_endofpacket   (response_endofpacket),
        .result_valid           (result_valid),
        .result_slot            (result_slot),
        .result_channel         (result_channel),
        .result_data            (result_data),
        .scan_done              (scan_done),
        .err_timeout            (err_timeout),
        .err_mismatch           (err_mismatch)
    );

    typedef struct {int slot; int ch; int data;} res_t;
    typedef struct {string name; int act; int exp;} chk_t;

    res_t exp_q[$];
    chk_t chk_q[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    int   scan_cnt = 0;
    int   cyc      = 0;

    // responder controls (written by stimulus) and observations (written by responder)
    int drop_ch   = 0;
    int bad_ch    = 0;
    int full_mode = 0;
    int scan_id   = 0;
    int hs_total  = 0;
    int hs_ch     = 0;
    int hs_cnt    = 0;
    int t_drop_hs = 0;

    initial clock_clk = 1'b0;
    always #5 clock_clk = ~clock_clk;

    initial forever begin
        @(posedge clock_clk);
        cyc++;
    end

    function automatic void post(input string name, input int act, input int exp);
        chk_q.push_back('{name, act, exp});
    endfunction

    function automatic void cmp(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    // Monitor: drains posted checks and scores every published result
    initial begin : monitor
        chk_t c;
        res_t r;
        forever begin
            @(negedge clock_clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                cmp(c.name, c.act, c.exp);
            end
            if (!reset_reset && result_valid) begin
                if (exp_q.size() == 0) begin
                    cmp("unexpected_result_slot", int'(result_slot), -1);
                end else begin
                    r = exp_q.pop_front();
                    cmp("result_slot", int'(result_slot), r.slot);
                    cmp("result_channel", int'(result_channel), r.ch);
                    cmp("result_data", int'(result_data), r.data);
                end
            end
            if (!reset_reset && scan_done) scan_cnt++;
        end
    end

    // ADC responder: answers each accepted command two cycles later
    initial begin : responder
        int pend_cnt;
        int pend_ch;
        int pend_data;
        int last_ch;
        int cnt;
        int seen_id;
        pend_cnt = 0; pend_ch = 0; pend_data = 0; last_ch = -1; cnt = 0; seen_id = -1;
        response_valid = 1'b0; response_channel = '0; response_data = '0;
        response_startofpacket = 1'b0; response_endofpacket = 1'b0;
        forever begin
            @(negedge clock_clk);
            #1;
            response_valid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    response_valid   = 1'b1;
                    response_channel = 5'(pend_ch);
                    response_data    = 12'(pend_data);
                end
            end
            if (!reset_reset && command_valid && command_ready) begin
                if (seen_id != scan_id) begin
                    seen_id = scan_id;
                    last_ch = -1;
                end
                cnt      = (int'(command_channel) == last_ch) ? cnt + 1 : 0;
                last_ch  = int'(command_channel);
                hs_total++;
                hs_ch    = last_ch;
                hs_cnt   = cnt;
                post("cmd_sop", int'(command_startofpacket), int'(hs_ch == 1 && cnt == 0));
                post("cmd_eop", int'(command_endofpacket), int'(hs_ch == 4 && cnt == 3));
                if (hs_ch == drop_ch) begin
                    t_drop_hs = cyc + 1;
                end else begin
                    pend_cnt  = 2;
                    pend_ch   = (hs_ch == bad_ch && cnt == 0) ? 7 : hs_ch;
                    pend_data = full_mode != 0 ? 4095 : 100 * hs_ch + cnt * hs_ch;
                end
            end
        end
    end

    task automatic start_scan();
        scan_id++;
        enable = 1'b1;
    endtask

    task automatic finish_scan(input int budget);
        int got;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock_clk);
            if (scan_done) begin
                got = 1;
                break;
            end
        end
        post("scan_done_seen", got, 1);
        enable = 1'b0;
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock_clk);
            if (command_valid) n++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int h0;
        int n;
        int got;
        reset_reset = 1'b1; enable = 1'b0; clear_err = 1'b0; command_ready = 1'b1;
        repeat (3) @(negedge clock_clk);
        post("rst_cmd_valid", int'(command_valid), 0);
        post("rst_cmd_channel", int'(command_channel), 0);
        post("rst_cmd_sop", int'(command_startofpacket), 0);
        post("rst_result_valid", int'(result_valid), 0);
        post("rst_result_data", int'(result_data), 0);
        post("rst_scan_done", int'(scan_done), 0);
        post("rst_err_timeout", int'(err_timeout), 0);
        post("rst_err_mismatch", int'(err_mismatch), 0);
        reset_reset = 1'b0;
        repeat (2) @(negedge clock_clk);

        // Full scan with ramp data
        exp_q.push_back('{0, 1, 101});
        exp_q.push_back('{1, 2, 203});
        exp_q.push_back('{2, 3, 304});
        exp_q.push_back('{3, 4, 406});
        h0 = hs_total;
        start_scan();
        finish_scan(2000);
        post("t1_cmd_count", hs_total - h0, 16);
        count_valid(10, n);
        post("t1_idle_no_cmd", n, 0);
        post("t1_scan_cnt", scan_cnt, 1);

        // Full-scale samples: accumulator must not overflow
        full_mode = 1;
        for (int s = 0; s < 4; s++) exp_q.push_back('{s, s + 1, 4095});
        start_scan();
        finish_scan(2000);
        full_mode = 0;
        repeat (2) @(negedge clock_clk);
        post("t1b_scan_cnt", scan_cnt, 2);

        // Backpressure on the first command, then a timeout on slot 2
        command_ready = 1'b0;
        drop_ch = 3;
        exp_q.push_back('{0, 1, 101});
        exp_q.push_back('{1, 2, 203});
        exp_q.push_back('{3, 4, 406});
        start_scan();
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock_clk);
            if (command_valid) begin
                got = 1;
                break;
            end
        end
        post("t2_valid_seen", got, 1);
        h0 = hs_total;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_clk);
            if (command_valid && command_channel == 5'd1 && command_startofpacket) n++;
        end
        post("t2_held_stable", n, 5);
        post("t2_no_xfer", hs_total - h0, 0);
        command_ready = 1'b1;
        repeat (2) @(negedge clock_clk);
        post("t2_one_xfer", hs_total - h0, 1);
        got = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clock_clk);
            if (err_timeout) begin
                got = 1;
                break;
            end
        end
        post("t3_timeout_seen", got, 1);
        post("t3_timeout_latency", cyc - t_drop_hs, 1024);
        finish_scan(2000);
        drop_ch = 0;
        repeat (2) @(negedge clock_clk);
        post("t3_err_timeout", int'(err_timeout), 1);
        post("t3_err_mismatch", int'(err_mismatch), 0);
        post("t3_scan_cnt", scan_cnt, 3);

        // Channel mismatch on slot 1, then clear the sticky flags
        post("t4_timeout_sticky", int'(err_timeout), 1);
        bad_ch = 2;
        exp_q.push_back('{0, 1, 101});
        exp_q.push_back('{2, 3, 304});
        exp_q.push_back('{3, 4, 406});
        start_scan();
        finish_scan(2000);
        bad_ch = 0;
        repeat (2) @(negedge clock_clk);
        post("t4_err_mismatch", int'(err_mismatch), 1);
        post("t4_scan_cnt", scan_cnt, 4);
        clear_err = 1'b1;
        @(negedge clock_clk);
        clear_err = 1'b0;
        post("t4_clr_timeout", int'(err_timeout), 0);
        post("t4_clr_mismatch", int'(err_mismatch), 0);

        // Drop enable while slot 1 sample 2 is outstanding
        exp_q.push_back('{0, 1, 101});
        h0 = hs_total;
        start_scan();
        got = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clock_clk);
            if (hs_total > h0 && hs_ch == 2 && hs_cnt == 2) begin
                got = 1;
                break;
            end
        end
        post("t5_reached_s1_n2", got, 1);
        enable = 1'b0;
        h0 = hs_total;
        count_valid(30, n);
        post("t5_no_cmd", n, 0);
        post("t5_no_more_xfer", hs_total - h0, 0);
        post("t5_exp_drained", exp_q.size(), 0);
        post("t5_scan_cnt", scan_cnt, 4);

        // Asynchronous reset while waiting for a response
        h0 = hs_total;
        start_scan();
        got = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock_clk);
            if (hs_total > h0) begin
                got = 1;
                break;
            end
        end
        post("t6_first_xfer", got, 1);
        post("t6_pre_channel", int'(command_channel), 1);
        post("t6_pre_result_data", int'(result_data), 101);
        #2 reset_reset = 1'b1;
        #1;
        post("t6_rst_cmd_channel", int'(command_channel), 0);
        post("t6_rst_cmd_valid", int'(command_valid), 0);
        post("t6_rst_result_data", int'(result_data), 0);
        post("t6_rst_result_channel", int'(result_channel), 0);
        scan_id++;
        repeat (3) @(negedge clock_clk);
        reset_reset = 1'b0;
        h0 = hs_total;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock_clk);
            if (command_valid) begin
                got = 1;
                break;
            end
        end
        post("t6_restart_valid", got, 1);
        post("t6_restart_channel", int'(command_channel), 1);
        post("t6_restart_sop", int'(command_startofpacket), 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock_clk);
            if (hs_total > h0) break;
        end
        enable = 1'b0;
        count_valid(30, n);
        post("t6_idle_no_cmd", n, 0);
        post("t6_exp_drained", exp_q.size(), 0);
        post("t6_scan_cnt", scan_cnt, 4);

        repeat (3) @(negedge clock_clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
